// File: rtl/ila_fifo_readout_if.sv
// FIFO read-port and byte-stream signal bundle for the ILA readout stage.
// master = readout (pops FIFO, drives stream); slave = FIFO + host link side.
interface ila_fifo_readout_if #(
  parameter int DATA_WIDTH = 20
);
  logic                  FIFO_EN;
  logic [DATA_WIDTH-1:0] FIFO_DO;
  logic                  FIFO_EMPTY;
  logic [7:0]            TX_DATA;
  logic                  TX_VALID;
  logic                  TX_READY;

  modport master (
    output FIFO_EN, TX_DATA, TX_VALID,
    input  FIFO_DO, FIFO_EMPTY, TX_READY
  );

  modport slave (
    input  FIFO_EN, TX_DATA, TX_VALID,
    output FIFO_DO, FIFO_EMPTY, TX_READY
  );
endinterface

// File: rtl/ila_fifo_readout.sv
// Drains ILA FIFO words into a framed byte stream (header, 16-bit count, words LSB first).
// Header valid 1 cycle after START; BYTES_PER_WORD+2 cycles/word; holds TX byte stable while TX_READY low.
module ila_fifo_readout #(
  parameter int         DATA_WIDTH  = 20,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic                    A_CLK,
  input  logic                    F_RST,
  input  logic                    START,
  input  logic [15:0]             WORD_COUNT,
  input  logic                    ABORT,
  ila_fifo_readout_if.master      bus,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ABORTED,
  output logic [15:0]             WORDS_LEFT
);
  localparam int BYTES_PER_WORD = (DATA_WIDTH + 7) / 8;
  localparam int SHIFT_W        = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {IDLE, HDR, CNT_LO, CNT_HI, POP, LOAD, SEND, FIN} state_t;

  state_t             state, state_nxt;
  logic [SHIFT_W-1:0] shift;
  logic [2:0]         byte_idx;
  logic               abort_pend;
  logic               tx_fire;
  logic               abort_req;
  logic               last_byte;
  logic               in_tx_state;

  assign tx_fire     = bus.TX_VALID && bus.TX_READY;
  assign abort_req   = ABORT || abort_pend;
  assign last_byte   = (byte_idx == 3'(BYTES_PER_WORD - 1));
  assign in_tx_state = (state == HDR) || (state == CNT_LO) || (state == CNT_HI) || (state == SEND);
  assign BUSY        = (state != IDLE);
  assign DONE        = (state == FIN);

  always_comb begin
    state_nxt    = state;
    bus.TX_VALID = 1'b0;
    bus.TX_DATA  = 8'h00;
    bus.FIFO_EN  = 1'b0;
    case (state)
      IDLE: if (START) state_nxt = HDR;
      HDR: begin
        bus.TX_VALID = 1'b1;
        bus.TX_DATA  = HEADER_BYTE;
        if (tx_fire) state_nxt = abort_req ? FIN : CNT_LO;
      end
      CNT_LO: begin
        bus.TX_VALID = 1'b1;
        bus.TX_DATA  = WORDS_LEFT[7:0];
        if (tx_fire) state_nxt = abort_req ? FIN : CNT_HI;
      end
      CNT_HI: begin
        bus.TX_VALID = 1'b1;
        bus.TX_DATA  = WORDS_LEFT[15:8];
        if (tx_fire) state_nxt = (abort_req || WORDS_LEFT == 16'd0) ? FIN : POP;
      end
      POP: begin
        if (abort_req) begin
          state_nxt = FIN;
        end else if (!bus.FIFO_EMPTY) begin
          // Gate with reset so a reset edge never coincides with a pop.
          bus.FIFO_EN = !F_RST;
          state_nxt   = LOAD;
        end
      end
      LOAD: state_nxt = abort_req ? FIN : SEND;
      SEND: begin
        bus.TX_VALID = 1'b1;
        bus.TX_DATA  = shift[7:0];
        if (tx_fire) begin
          if (abort_req || (last_byte && WORDS_LEFT == 16'd0)) state_nxt = FIN;
          else if (last_byte)                                   state_nxt = POP;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge A_CLK) begin
    if (F_RST) begin
      state      <= IDLE;
      shift      <= '0;
      byte_idx   <= 3'd0;
      abort_pend <= 1'b0;
      ABORTED    <= 1'b0;
      WORDS_LEFT <= 16'd0;
    end else begin
      state <= state_nxt;
      // An abort seen mid-handshake waits for the current byte to be accepted.
      abort_pend <= in_tx_state && abort_req && !tx_fire;
      if (state == IDLE && START) begin
        WORDS_LEFT <= WORD_COUNT;
        ABORTED    <= 1'b0;
      end
      if (state != IDLE && state != FIN && state_nxt == FIN && abort_req) ABORTED <= 1'b1;
      if (state == LOAD) begin
        shift      <= SHIFT_W'(bus.FIFO_DO);
        byte_idx   <= 3'd0;
        WORDS_LEFT <= WORDS_LEFT - 16'd1;
      end
      if (state == SEND && tx_fire) begin
        shift    <= shift >> 8;
        byte_idx <= byte_idx + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_ila_fifo_readout.sv
// Randomized bench: FIFO model, random sink backpressure, framed-stream reference model.
// Each dump is compared byte-for-byte plus pop/DONE/ABORTED/WORDS_LEFT bookkeeping.
module tb_ila_fifo_readout;
  localparam int DW  = 20;
  localparam int BPW = (DW + 7) / 8;

  logic        A_CLK = 1'b0;
  logic        F_RST;
  logic        START;
  logic [15:0] WORD_COUNT;
  logic        ABORT;
  logic        BUSY, DONE, ABORTED;
  logic [15:0] WORDS_LEFT;

  ila_fifo_readout_if #(.DATA_WIDTH(DW)) bus ();

  ila_fifo_readout #(.DATA_WIDTH(DW), .HEADER_BYTE(8'hA5)) dut (
    .A_CLK      (A_CLK),
    .F_RST      (F_RST),
    .START      (START),
    .WORD_COUNT (WORD_COUNT),
    .ABORT      (ABORT),
    .bus        (bus),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ABORTED    (ABORTED),
    .WORDS_LEFT (WORDS_LEFT)
  );

  always #5 A_CLK = ~A_CLK;

  int n_checks = 0;
  int n_errs   = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] fifo_do_r = '0;
  logic [DW-1:0] exp_words[$];
  logic [7:0]    rx[$];
  logic [7:0]    exp_bytes[$];

  assign bus.FIFO_DO = fifo_do_r;

  // FIFO read port: data appears the cycle after the pop strobe.
  always @(posedge A_CLK) begin
    if (bus.FIFO_EN && fifo_q.size() > 0) fifo_do_r <= fifo_q.pop_front();
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // n words, ready probability in %, stall before word index, abort after that many
  // received bytes, reset after that many received bytes (-1 disables each).
  task automatic dump(input int n, input int rdy_pct, input int stall_word,
                      input int abort_at, input int rst_at);
    int  pops = 0, dones = 0, unstable = 0, stall_cnt = 0, stall_idle = 0, stall_leak = 0;
    int  phase = 0, hold = 0, exp_pops;
    bit  force_empty, prev_hold = 0, finished = 0, rst_phase = 0;
    logic [7:0] prev_dat = '0;

    fifo_q.delete();
    rx.delete();
    foreach (exp_words[i]) fifo_q.push_back(exp_words[i]);

    exp_bytes.delete();
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'(n & 'hFF));
    exp_bytes.push_back(8'((n >> 8) & 'hFF));
    for (int w = 0; w < n && w < exp_words.size(); w++)
      for (int b = 0; b < BPW; b++) exp_bytes.push_back(8'((32'(exp_words[w]) >> (8 * b)) & 'hFF));
    if (abort_at >= 0) begin
      while (exp_bytes.size() > abort_at + 1) void'(exp_bytes.pop_back());
      exp_pops = (abort_at + 1 - 3 > 0) ? (abort_at + 1 - 3 + BPW - 1) / BPW : 0;
    end else begin
      exp_pops = n;
    end

    @(negedge A_CLK);
    START          = 1'b1;
    WORD_COUNT     = n[15:0];
    ABORT          = 1'b0;
    bus.TX_READY   = 1'b0;
    bus.FIFO_EMPTY = (fifo_q.size() == 0);

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge A_CLK);
      START = 1'b0;
      if (rst_phase) begin
        F_RST = 1'b0;
        #1;
        chk("rst_outputs", {bus.TX_VALID, bus.TX_DATA, bus.FIFO_EN, BUSY, DONE, ABORTED, WORDS_LEFT}, '0);
        chk("rst_no_pop_after", 32'(fifo_q.size()), 32'(exp_words.size() - 1));
        return;
      end
      if (phase == 1) begin
        ABORT = 1'b1; bus.TX_READY = 1'b0;
        if (++hold == 2) phase = 2;
      end else begin
        ABORT = 1'b0;
        bus.TX_READY = ($urandom_range(0, 99) < rdy_pct);
      end
      force_empty = (stall_word >= 0 && pops == stall_word && stall_cnt < 10);
      if (force_empty) stall_cnt++;
      bus.FIFO_EMPTY = force_empty || (fifo_q.size() == 0);
      if (rst_at >= 0 && rx.size() == rst_at) begin
        F_RST = 1'b1;
        rst_phase = 1;
      end
      #1;
      if (cyc == 0) begin
        chk("hdr_valid", bus.TX_VALID, 1);
        chk("hdr_data", bus.TX_DATA, 8'hA5);
        chk("busy_after_start", BUSY, 1);
        chk("aborted_cleared", ABORTED, 0);
        chk("words_left_latch", WORDS_LEFT, n[15:0]);
      end
      if (prev_hold && (!bus.TX_VALID || bus.TX_DATA !== prev_dat)) unstable++;
      prev_hold = bus.TX_VALID && !bus.TX_READY;
      prev_dat  = bus.TX_DATA;
      if (bus.TX_VALID && bus.TX_READY && !rst_phase) rx.push_back(bus.TX_DATA);
      if (bus.FIFO_EN) pops++;
      if (force_empty && bus.FIFO_EN) stall_leak++;
      if (force_empty && !bus.FIFO_EN && !bus.TX_VALID) stall_idle++;
      if (DONE) begin
        dones++;
        finished = 1;
        chk("words_left_end", WORDS_LEFT, 32'(n - exp_pops));
      end
      if (abort_at >= 0 && phase == 0 && rx.size() == abort_at) phase = 1;
    end

    chk("dump_finished", finished, 1);
    chk("done_pulses", dones, 1);
    chk("pops", pops, exp_pops);
    chk("aborted", ABORTED, (abort_at >= 0));
    chk("tx_stable", unstable, 0);
    chk("byte_count", rx.size(), exp_bytes.size());
    for (int i = 0; i < rx.size() && i < exp_bytes.size(); i++)
      chk($sformatf("byte%0d", i), rx[i], exp_bytes[i]);
    if (stall_word >= 0) begin
      chk("stall_no_pop", stall_leak, 0);
      chk("stall_hold", stall_idle, 10 - BPW);
    end
    @(negedge A_CLK);
    bus.TX_READY = 1'b0;
    #1;
    chk("busy_after_done", BUSY, 0);
    chk("done_single", DONE, 0);
  endtask

  initial begin
    F_RST = 1'b1; START = 1'b0; WORD_COUNT = '0; ABORT = 1'b0;
    bus.TX_READY = 1'b0; bus.FIFO_EMPTY = 1'b1;
    repeat (3) @(negedge A_CLK);
    #1;
    chk("reset_outputs", {bus.TX_VALID, bus.TX_DATA, bus.FIFO_EN, BUSY, DONE, ABORTED, WORDS_LEFT}, '0);
    @(negedge A_CLK);
    F_RST = 1'b0;

    exp_words = '{20'h12345, 20'hABCDE};
    dump(2, 100, -1, -1, -1);

    exp_words.delete();
    dump(0, 100, -1, -1, -1);

    exp_words = '{20'h12345, 20'hABCDE};
    dump(2, 45, -1, -1, -1);

    exp_words.delete();
    for (int i = 0; i < 3; i++) exp_words.push_back(DW'($urandom));
    dump(3, 100, 1, -1, -1);

    exp_words.delete();
    for (int i = 0; i < 3; i++) exp_words.push_back(DW'($urandom));
    dump(3, 100, -1, 4, -1);

    exp_words.delete();
    for (int i = 0; i < 2; i++) exp_words.push_back(DW'($urandom));
    dump(2, 70, -1, -1, -1);

    exp_words.delete();
    dump(16'hFFFF, 100, -1, 2, -1);

    exp_words.delete();
    for (int i = 0; i < 3; i++) exp_words.push_back(DW'($urandom));
    dump(3, 100, -1, -1, 5);

    exp_words.delete();
    for (int i = 0; i < 2; i++) exp_words.push_back(DW'($urandom));
    dump(2, 100, -1, -1, -1);

    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 6);
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back(DW'($urandom));
      dump(n, $urandom_range(25, 100), -1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
